// File: rtl/uart_packet_framer_pkg.sv
// Shared types for the UART packet framer: the response-stream beat, the TX FSM state
// and the default frame sync byte.
package uart_packet_framer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;

  typedef enum logic [2:0] {IDLE, SYNC, DEST, SRC, LEN, DATA, WAIT} FramerState;

endpackage

// File: rtl/uart_packet_framer_if.sv
// Producer-to-framer link: the UART_PACKET beat going downstream and the pacing ready coming back.
interface uart_packet_framer_if;
  import uart_packet_framer_pkg::*;

  UART_PACKET txStream;
  logic       txReady;

  modport master (output txStream, input txReady);
  modport slave  (input txStream, output txReady);
endinterface

// File: rtl/uart_packet_framer_fifo.sv
// Synchronous first-word-fall-through byte FIFO; dout shows the head entry whenever not empty.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   ipClk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doWr;
  logic          doRd;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign doWr  = wr && !full;
  assign doRd  = rd && !empty;
  assign dout  = mem[rdPtr];

  always_ff @(posedge ipClk) begin
    if (doWr) mem[wrPtr] <= din;
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      case ({doWr, doRd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_packet_framer.sv
// Serialises UART_PACKET responses as SYNC, Dest, Src, Len, payload onto the UART byte port,
// padding short packets with zeros and pacing the producer through txReady.
module uart_packet_framer
  import uart_packet_framer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned READY_GAP  = 2,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                    ipClk,
  input  logic                    reset,
  uart_packet_framer_if.slave     ipTxStream,
  input  logic                    ipUartBusy,
  output logic [7:0]              opUartData,
  output logic                    opUartSend,
  output logic                    opFrameError,
  output logic                    opOverflow
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(READY_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(READY_GAP - 1);

  UART_PACKET    inPkt;
  logic          opTxReady;
  logic [GW-1:0] gapCnt;
  logic [7:0]    destReg, srcReg, lenReg;
  logic [7:0]    rxCount, txCount, padCount;
  logic          hdrPending, errSeen;
  logic          newHdr, fifoWr, fifoRd, fifoEmpty, fifoFull;
  logic          dropLong, shortEop, frameErrHit;
  logic [7:0]    rxCur, lenCur, fifoDout;
  logic [CW-1:0] fifoCount;

  FramerState    state, stateNext, retState, retNext;
  logic          sawBusy, sawBusyNext, canSend;
  logic          sendNext, hdrDone, padDec, txInc, txClr;
  logic [7:0]    dataNext;

  assign inPkt = ipTxStream.txStream;
  assign ipTxStream.txReady = opTxReady;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) byteFifo (
    .ipClk (ipClk),
    .reset (reset),
    .wr    (fifoWr),
    .rd    (fifoRd),
    .din   (inPkt.Data),
    .dout  (fifoDout),
    .empty (fifoEmpty),
    .full  (fifoFull),
    .count (fifoCount)
  );

  // A fresh SoP byte is judged against its own header, hence the rxCur/lenCur bypass.
  always_comb begin
    newHdr      = inPkt.Valid && inPkt.SoP && !hdrPending;
    rxCur       = newHdr ? '0 : rxCount;
    lenCur      = newHdr ? inPkt.Length : lenReg;
    fifoWr      = inPkt.Valid && !fifoFull && (rxCur < lenCur);
    dropLong    = inPkt.Valid && !fifoFull && (rxCur >= lenCur);
    shortEop    = inPkt.Valid && inPkt.EoP && (({1'b0, rxCur} + 9'd1) < {1'b0, lenCur});
    frameErrHit = (dropLong || shortEop) && (newHdr || !errSeen);
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      destReg      <= '0;
      srcReg       <= '0;
      lenReg       <= '0;
      rxCount      <= '0;
      padCount     <= '0;
      hdrPending   <= 1'b0;
      errSeen      <= 1'b0;
      opFrameError <= 1'b0;
      opOverflow   <= 1'b0;
      opTxReady    <= 1'b0;
      gapCnt       <= '0;
    end else begin
      opFrameError <= frameErrHit;
      opOverflow   <= inPkt.Valid && fifoFull;
      if (newHdr) begin
        destReg <= inPkt.Destination;
        srcReg  <= inPkt.Source;
        lenReg  <= inPkt.Length;
        errSeen <= 1'b0;
      end
      if (frameErrHit) errSeen <= 1'b1;
      if (fifoWr)      rxCount <= rxCur + 8'd1;
      else if (newHdr) rxCount <= '0;
      if (newHdr)       hdrPending <= 1'b1;
      else if (hdrDone) hdrPending <= 1'b0;
      if (shortEop)     padCount <= lenCur - rxCur - 8'd1;
      else if (newHdr)  padCount <= '0;
      else if (padDec)  padCount <= padCount - 8'd1;
      if (inPkt.Valid) begin
        opTxReady <= 1'b0;
        gapCnt    <= GAP_LOAD;
      end else if (gapCnt != '0) begin
        opTxReady <= 1'b0;
        gapCnt    <= gapCnt - 1'b1;
      end else begin
        opTxReady <= (fifoCount < CW'(FIFO_DEPTH - 1));
      end
    end
  end

  // Header fields share one send path; WAIT returns to retState once busy has risen and fallen.
  always_comb begin
    stateNext   = state;
    retNext     = retState;
    sawBusyNext = sawBusy;
    sendNext    = 1'b0;
    dataNext    = opUartData;
    hdrDone     = 1'b0;
    padDec      = 1'b0;
    fifoRd      = 1'b0;
    txInc       = 1'b0;
    txClr       = 1'b0;
    canSend     = !ipUartBusy && !opUartSend;
    unique case (state)
      IDLE: begin
        if (hdrPending) begin
          stateNext = SYNC;
          txClr     = 1'b1;
        end
      end
      SYNC, DEST, SRC, LEN: begin
        if (canSend) begin
          sendNext    = 1'b1;
          sawBusyNext = 1'b0;
          stateNext   = WAIT;
          case (state)
            SYNC:    begin dataNext = SYNC_BYTE; retNext = DEST; end
            DEST:    begin dataNext = destReg;   retNext = SRC;  end
            SRC:     begin dataNext = srcReg;    retNext = LEN;  end
            default: begin dataNext = lenReg;    retNext = DATA; end
          endcase
        end
      end
      DATA: begin
        if (txCount == lenReg) begin
          hdrDone   = 1'b1;
          stateNext = IDLE;
        end else if (canSend && (!fifoEmpty || padCount != '0)) begin
          sendNext    = 1'b1;
          sawBusyNext = 1'b0;
          txInc       = 1'b1;
          stateNext   = WAIT;
          retNext     = DATA;
          if (!fifoEmpty) begin
            dataNext = fifoDout;
            fifoRd   = 1'b1;
          end else begin
            dataNext = '0;
            padDec   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (ipUartBusy)   sawBusyNext = 1'b1;
        else if (sawBusy) stateNext   = retState;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      state      <= IDLE;
      retState   <= IDLE;
      sawBusy    <= 1'b0;
      opUartSend <= 1'b0;
      opUartData <= '0;
      txCount    <= '0;
    end else begin
      state      <= stateNext;
      retState   <= retNext;
      sawBusy    <= sawBusyNext;
      opUartSend <= sendNext;
      opUartData <= dataNext;
      if (txClr)      txCount <= '0;
      else if (txInc) txCount <= txCount + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_packet_framer.sv
// Randomised self-checking bench: frames are predicted from the packet contents alone
// (header, first Length bytes, zero padding) and compared against captured UART bytes.
module tb_uart_packet_framer;
  import uart_packet_framer_pkg::*;

  localparam int GAP = 2;

  logic ipClk = 1'b0;
  logic reset;
  always #5 ipClk = ~ipClk;

  uart_packet_framer_if bus0();
  uart_packet_framer_if bus1();

  logic       busy0, busy1R, hold1, busy1;
  logic [7:0] data0, data1;
  logic       send0, send1, ferr0, ferr1, ovf0, ovf1;
  assign busy1 = busy1R | hold1;

  uart_packet_framer #(.FIFO_DEPTH(16), .READY_GAP(GAP), .SYNC_BYTE(8'h55)) dut (
    .ipClk(ipClk), .reset(reset), .ipTxStream(bus0), .ipUartBusy(busy0),
    .opUartData(data0), .opUartSend(send0), .opFrameError(ferr0), .opOverflow(ovf0));

  uart_packet_framer #(.FIFO_DEPTH(4), .READY_GAP(GAP), .SYNC_BYTE(8'h55)) dut4 (
    .ipClk(ipClk), .reset(reset), .ipTxStream(bus1), .ipUartBusy(busy1),
    .opUartData(data1), .opUartSend(send1), .opFrameError(ferr1), .opOverflow(ovf1));

  int         nChecks = 0;
  int         nPass = 0;
  int         errCnt0 = 0, ovfCnt0 = 0, errCnt1 = 0, ovfCnt1 = 0;
  int         busyLen = 10;
  logic [7:0] wire0[$];
  logic [7:0] wire1[$];
  logic [7:0] txBytes[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // UART models: capture each strobed byte, then stay busy for a while.
  initial begin : uart0
    int n;
    busy0 = 1'b0;
    forever begin
      @(posedge ipClk); #1;
      if (send0) begin
        wire0.push_back(data0);
        busy0 = 1'b1;
        n = (busyLen > 0) ? busyLen : int'($urandom_range(1, 5));
        repeat (n) @(posedge ipClk);
        #1 busy0 = 1'b0;
      end
    end
  end

  initial begin : uart1
    int n;
    busy1R = 1'b0;
    forever begin
      @(posedge ipClk); #1;
      if (send1) begin
        wire1.push_back(data1);
        busy1R = 1'b1;
        n = (busyLen > 0) ? busyLen : int'($urandom_range(1, 5));
        repeat (n) @(posedge ipClk);
        #1 busy1R = 1'b0;
      end
    end
  end

  initial begin : pulseMon
    forever begin
      @(posedge ipClk); #1;
      if (!reset) begin
        errCnt0 += int'(ferr0);
        ovfCnt0 += int'(ovf0);
        errCnt1 += int'(ferr1);
        ovfCnt1 += int'(ovf1);
      end
    end
  end

  // Producer: one byte per observed ready rise, EoP on the last byte of txBytes.
  task automatic sendPacket(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len,
                            input bit exactGap, input bit chkLat);
    UART_PACKET p;
    int waitCnt, lowCnt, sendK, k;
    bit done;
    for (int i = 0; i < txBytes.size(); i++) begin
      waitCnt = 0;
      while (!bus0.txReady && waitCnt < 400) begin
        @(posedge ipClk); #1;
        waitCnt++;
      end
      if (!bus0.txReady) begin
        check("readyTimeout", 32'(bus0.txReady), 32'd1);
        return;
      end
      p = '0;
      p.Destination = dst;
      p.Source      = src;
      p.Length      = len;
      p.SoP         = (i == 0);
      p.EoP         = (i == txBytes.size() - 1);
      p.Data        = txBytes[i];
      p.Valid       = 1'b1;
      bus0.txStream = p;
      @(posedge ipClk); #1;
      bus0.txStream = '0;
      lowCnt = 0; sendK = 0; k = 1; done = 0;
      while (!done) begin
        if (send0 && sendK == 0) sendK = k;
        if (bus0.txReady || k > 60) done = 1;
        else begin
          lowCnt++; k++;
          @(posedge ipClk); #1;
        end
      end
      if (exactGap) check("readyGap", 32'(lowCnt), 32'(GAP));
      else          check("readyGapMin", 32'(lowCnt >= GAP), 32'd1);
      // sample k=1 follows the accepting edge, so two cycles later is k=3
      if (chkLat && i == 0) check("sendLatency", 32'(sendK), 32'd3);
    end
  endtask

  task automatic runPacket(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len,
                           input bit exactGap, input bit chkLat, input string tag);
    logic [7:0] exp[$];
    int n, e0, o0, t;
    n  = txBytes.size();
    e0 = errCnt0;
    o0 = ovfCnt0;
    exp.push_back(8'h55);
    exp.push_back(dst);
    exp.push_back(src);
    exp.push_back(len);
    for (int i = 0; i < int'(len); i++) exp.push_back(i < n ? txBytes[i] : 8'h00);
    wire0.delete();
    sendPacket(dst, src, len, exactGap, chkLat);
    t = 0;
    while (wire0.size() < exp.size() && t < 4000) begin
      @(posedge ipClk); #1;
      t++;
    end
    repeat (30) @(posedge ipClk);
    #1;
    check({tag, " frameLen"}, 32'(wire0.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wire0.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(wire0[i]), 32'(exp[i]));
    check({tag, " frameErr"}, 32'(errCnt0 - e0), (n != int'(len)) ? 32'd1 : 32'd0);
    check({tag, " overflow"}, 32'(ovfCnt0 - o0), 32'd0);
  endtask

  initial begin : stimulus
    UART_PACKET p;
    logic [7:0] ovfBytes[$];
    logic [7:0] len;
    int n, t, e1, o1, e0;

    bus0.txStream = '0;
    bus1.txStream = '0;
    hold1 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge ipClk);
    #1;
    check("rstReady", 32'(bus0.txReady), 32'd0);
    check("rstData", 32'(data0), 32'd0);
    check("rstSend", 32'(send0), 32'd0);
    check("rstFrameErr", 32'(ferr0), 32'd0);
    check("rstOverflow", 32'(ovf0), 32'd0);
    reset = 1'b0;
    @(posedge ipClk); #1;
    check("readyAfterReset", 32'(bus0.txReady), 32'd1);

    busyLen = 10;
    txBytes = {};
    txBytes.push_back(8'hDE); txBytes.push_back(8'hAD);
    txBytes.push_back(8'hBE); txBytes.push_back(8'hEF);
    runPacket(8'h01, 8'h00, 8'd4, 1'b1, 1'b1, "basic");

    busyLen = 3;
    txBytes = {};
    txBytes.push_back(8'h11); txBytes.push_back(8'h22);
    runPacket(8'h12, 8'h34, 8'd4, 1'b1, 1'b0, "shortEop");

    txBytes = {};
    txBytes.push_back(8'hA1); txBytes.push_back(8'hA2); txBytes.push_back(8'hA3);
    runPacket(8'h56, 8'h78, 8'd2, 1'b1, 1'b0, "longPkt");

    busyLen = 0;
    for (int r = 0; r < 12; r++) begin
      len = 8'($urandom_range(0, 20));
      n = int'(len) + int'($urandom_range(0, 4)) - 2;
      if (n < 1) n = 1;
      txBytes = {};
      for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom));
      runPacket(8'($urandom), 8'($urandom), len, 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

    // Depth-4 instance: UART held busy while six bytes are forced in back to back.
    busyLen = 2;
    hold1 = 1'b1;
    wire1.delete();
    e1 = errCnt1;
    o1 = ovfCnt1;
    for (int i = 0; i < 6; i++) begin
      p = '0;
      p.Destination = 8'hC3;
      p.Source      = 8'h3C;
      p.Length      = 8'd6;
      p.SoP         = (i == 0);
      p.Data        = 8'($urandom);
      p.Valid       = 1'b1;
      ovfBytes.push_back(p.Data);
      bus1.txStream = p;
      @(posedge ipClk); #1;
    end
    bus1.txStream = '0;
    repeat (3) @(posedge ipClk);
    #1;
    check("ovfPulses", 32'(ovfCnt1 - o1), 32'd2);
    check("ovfFrameErr", 32'(errCnt1 - e1), 32'd0);
    hold1 = 1'b0;
    t = 0;
    while (wire1.size() < 8 && t < 500) begin
      @(posedge ipClk); #1;
      t++;
    end
    repeat (60) @(posedge ipClk);
    #1;
    check("ovfFrameLen", 32'(wire1.size()), 32'd8);
    if (wire1.size() >= 8) begin
      check("ovfSync", 32'(wire1[0]), 32'h55);
      check("ovfLenField", 32'(wire1[3]), 32'd6);
      for (int i = 0; i < 4; i++) check($sformatf("ovfData%0d", i), 32'(wire1[4+i]), 32'(ovfBytes[i]));
    end

    // Reset in the middle of the payload, then a clean frame.
    busyLen = 10;
    e0 = errCnt0;
    txBytes = {};
    for (int i = 0; i < 4; i++) txBytes.push_back(8'($urandom));
    wire0.delete();
    sendPacket(8'h21, 8'h43, 8'd4, 1'b1, 1'b0);
    t = 0;
    while (wire0.size() < 6 && t < 500) begin
      @(posedge ipClk); #1;
      t++;
    end
    check("midFrameProgress", 32'(wire0.size()), 32'd6);
    reset = 1'b1;
    @(posedge ipClk); #1;
    check("midRstReady", 32'(bus0.txReady), 32'd0);
    check("midRstData", 32'(data0), 32'd0);
    check("midRstSend", 32'(send0), 32'd0);
    check("midRstFrameErr", 32'(ferr0), 32'd0);
    check("midRstOverflow", 32'(ovf0), 32'd0);
    @(posedge ipClk); #1;
    reset = 1'b0;
    repeat (20) @(posedge ipClk);
    #1;
    check("midRstSilent", 32'(errCnt0 - e0), 32'd0);
    busyLen = 4;
    txBytes = {};
    txBytes.push_back(8'h5A); txBytes.push_back(8'hC0); txBytes.push_back(8'h01);
    runPacket(8'h99, 8'h88, 8'd3, 1'b1, 1'b1, "afterRst");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
